fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the multicycle RISC-V core. It replaces the fixed-width PC / PC+4 adder / instruction-register / fetch-FSM cluster with a single block. The block adds configurable memory latency, a valid/ready handshake toward decode, and branch/jump redirect with squashing of in-flight fetches. It sits between the instruction memory and the decode/control FSM.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: multicycle RISC-V instruction fetch with latency counter, decode handshake and redirect squash.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> an unaligned redirect target enters FAULT and raises misalign
//   undefined -> redirect targets have bits [1:0] forced to zero; no misalign port
//
// Ports:
//   CLK            clock, rising edge
//   RST            asynchronous active-low reset
//   misalign       unaligned redirect fault flag (FETCH_ALIGN_CHECK_EN only)
//   mem_req        read strobe, high in REQ
//   mem_raddr      read address (the PC)
//   mem_rdata      read data, valid MEM_LAT cycles after the mem_req cycle
//   redirect_valid load redirect_pc and squash the current fetch
//   redirect_pc    redirect target
//   out_valid      instruction register holds an instruction for decode
//   out_ready      decode accepts the instruction
//   out_instr      instruction register
//   out_pc         PC of out_instr
//   out_opcode/out_rd/out_rs1/out_rs2  field slices of out_instr
module fetch_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_LAT = 1
) (
  input  logic            CLK,
  input  logic            RST,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            misalign,
`endif
  output logic            mem_req,
  output logic [XLEN-1:0] mem_raddr,
  input  logic [ILEN-1:0] mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [2:0] FAULT = 3'd4;
`endif
  localparam logic [XLEN-1:0] INC = XLEN'(ILEN / 8);
  localparam logic [2:0] LAT0 = 3'(MEM_LAT);
  logic [2:0] state_q, state_d, lat_q, lat_d;
  logic [XLEN-1:0] pc_q, pc_d, out_pc_q, out_pc_d, redir_pc;
  logic [ILEN-1:0] instr_q, instr_d;
  logic valid_q, valid_d, redir;
  // Redirects are ignored while still leaving reset.
  assign redir = redirect_valid && (state_q != IDLE);
`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d, redir_bad;
  assign redir_bad = redirect_pc[1:0] != 2'b00;
  assign redir_pc = redirect_pc;
  assign misalign = mis_q;
`else
  assign redir_pc = redirect_pc & ~XLEN'(3);
`endif
  assign mem_req = state_q == REQ;
  assign mem_raddr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc = out_pc_q;
  assign out_opcode = instr_q[6:0];
  assign out_rd = instr_q[11:7];
  assign out_rs1 = instr_q[19:15];
  assign out_rs2 = instr_q[24:20];
  // A redirect overrides everything, including a capture due on this edge;
  // a handshake coinciding with it still retires the held instruction.
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    pc_d = pc_q;
    instr_d = instr_q;
    out_pc_d = out_pc_q;
    valid_d = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d = mis_q;
`endif
    if (redir) begin
      pc_d = redir_pc;
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      state_d = redir_bad ? FAULT : REQ;
      mis_d = redir_bad;
`else
      state_d = REQ;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          lat_d = LAT0;
          state_d = WAIT;
        end
        WAIT: begin
          lat_d = lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            instr_d = mem_rdata;
            out_pc_d = pc_q;
            pc_d = pc_q + INC;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FAULT: state_d = FAULT;
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      lat_q <= 3'd0;
      pc_q <= RESET_PC;
      instr_q <= '0;
      out_pc_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      out_pc_q <= out_pc_d;
      valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q <= mis_d;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus hand sequences with a consumed-instruction scoreboard for fetch_stage.
module tb_fetch_stage;
  localparam logic [63:0] RPC = 64'h1000;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req1, valid1, ready1 = 1'b0, redir1 = 1'b0;
  logic [63:0] raddr1, rpc1 = '0, opc1;
  logic [31:0] rdata1, instr1;
  logic [6:0] op1;
  logic [4:0] rd1, rs11, rs21;
  logic req3, valid3, ready3 = 1'b0, redir3 = 1'b0;
  logic [63:0] raddr3, rpc3 = '0, opc3;
  logic [31:0] rdata3, instr3;
  logic [6:0] op3;
  logic [4:0] rd3, rs13, rs23;
`ifdef FETCH_ALIGN_CHECK_EN
  logic mis1, mis3;
`endif
  fetch_stage #(.XLEN(64), .ILEN(32), .RESET_PC(RPC), .MEM_LAT(1)) u1 (
    .CLK(clk), .RST(rst_n),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign(mis1),
`endif
    .mem_req(req1), .mem_raddr(raddr1), .mem_rdata(rdata1),
    .redirect_valid(redir1), .redirect_pc(rpc1),
    .out_valid(valid1), .out_ready(ready1), .out_instr(instr1), .out_pc(opc1),
    .out_opcode(op1), .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21));
  fetch_stage #(.XLEN(64), .ILEN(32), .RESET_PC(RPC), .MEM_LAT(3)) u3 (
    .CLK(clk), .RST(rst_n),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign(mis3),
`endif
    .mem_req(req3), .mem_raddr(raddr3), .mem_rdata(rdata3),
    .redirect_valid(redir3), .redirect_pc(rpc3),
    .out_valid(valid3), .out_ready(ready3), .out_instr(instr3), .out_pc(opc3),
    .out_opcode(op3), .out_rd(rd3), .out_rs1(rs13), .out_rs2(rs23));

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return (a == 64'h1000) ? 32'h00A00093 : (a[63:32] ^ a[31:0]) * 32'h9E3779B1 + 32'h13;
  endfunction

  // Memory model: data is only correct exactly MEM_LAT cycles after a request.
  logic pv1 = 1'b0;
  logic [63:0] pa1 = '0;
  logic pv3 [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] pa3 [3] = '{64'h0, 64'h0, 64'h0};
  always @(posedge clk) begin
    pv1 <= req1;
    pa1 <= raddr1;
    pv3[0] <= req3;
    pa3[0] <= raddr3;
    for (int i = 1; i < 3; i++) begin
      pv3[i] <= pv3[i-1];
      pa3[i] <= pa3[i-1];
    end
  end
  assign rdata1 = pv1 ? mem_fn(pa1) : 32'hDEADBEEF;
  assign rdata3 = pv3[2] ? mem_fn(pa3[2]) : 32'hDEADBEEF;

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [63:0] pc; logic [31:0] instr;} exp_t;
  exp_t sbq[$];
  exp_t sb_e;
  // Inputs change at negedge+2, so at negedge+3 a valid&ready pair is the handshake of the next edge.
  always @(negedge clk) begin
    #3;
    if (rst_n && valid1 && ready1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc 0x%0h, want no output", opc1);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_pc", opc1, sb_e.pc);
        chk("sb_instr", 64'(instr1), 64'(sb_e.instr));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid1();
    for (int k = 0; k < 20 && !valid1; k++) cyc();
    chk("wait_valid", 64'(valid1), 64'd1);
  endtask

  typedef struct {
    logic [63:0] rpc;
    logic rdy;
    logic exp_req;
    logic [63:0] exp_addr;
    logic exp_mis;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] cur_pc;
    logic in_fault;
    logic [31:0] e;
    int k;
    tbl[0] = '{64'h2000, 1'b1, 1'b1, 64'h2000, 1'b0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[2] = '{64'h3000, 1'b0, 1'b1, 64'h3000, 1'b0};
    tbl[6] = '{64'h5000, 1'b1, 1'b1, 64'h5000, 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
    tbl[1] = '{64'h2002, 1'b0, 1'b0, 64'h2002, 1'b1};
    tbl[4] = '{64'h4001, 1'b0, 1'b0, 64'h4001, 1'b1};
    tbl[5] = '{64'h4003, 1'b0, 1'b0, 64'h4003, 1'b1};
`else
    tbl[1] = '{64'h2002, 1'b0, 1'b1, 64'h2000, 1'b0};
    tbl[4] = '{64'h4001, 1'b0, 1'b1, 64'h4000, 1'b0};
    tbl[5] = '{64'h4003, 1'b0, 1'b1, 64'h4000, 1'b0};
`endif
    repeat (2) cyc();
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_req", 64'(req1), 64'd0);
    chk("rst_instr", 64'(instr1), 64'd0);
    chk("rst_out_pc", opc1, 64'd0);
    chk("rst_pc", raddr1, RPC);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_misalign", 64'(mis1), 64'd0);
`endif
    sbq.push_back('{RPC, 32'h00A00093});
    rst_n = 1'b1;
    cyc();
    chk("req_strobe", 64'(req1), 64'd1);
    chk("req_addr", raddr1, RPC);
    chk("req_valid", 64'(valid1), 64'd0);
    cyc();
    chk("wait_req", 64'(req1), 64'd0);
    chk("wait_valid_low", 64'(valid1), 64'd0);
    cyc();
    chk("first_valid", 64'(valid1), 64'd1);
    chk("first_pc", opc1, RPC);
    chk("first_instr", 64'(instr1), 64'h00A00093);
    chk("first_opcode", 64'(op1), 64'h13);
    chk("first_rd", 64'(rd1), 64'd1);
    chk("first_rs1", 64'(rs11), 64'd0);
    chk("first_rs2", 64'(rs21), 64'd10);
    chk("first_next_pc", raddr1, 64'h1004);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", 64'(valid1), 64'd1);
      chk("stall_pc", opc1, RPC);
      chk("stall_instr", 64'(instr1), 64'h00A00093);
      chk("stall_req", 64'(req1), 64'd0);
    end
    ready1 = 1'b1;
    cyc();
    chk("release_req", 64'(req1), 64'd1);
    chk("release_addr", raddr1, 64'h1004);
    chk("release_valid", 64'(valid1), 64'd0);
    for (int i = 0; i < 3; i++) sbq.push_back('{64'h1004 + 64'(4 * i), mem_fn(64'h1004 + 64'(4 * i))});
    for (k = 1; k < 30; k++) begin
      cyc();
      if (sbq.size() == 0) break;
    end
    chk("stream_cycles", 64'(k), 64'd9);
    chk("stream_next_req", 64'(req1), 64'd1);
    chk("stream_next_addr", raddr1, 64'h1010);
    ready1 = 1'b0;
    cur_pc = 64'h1010;
    in_fault = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!in_fault) begin
        wait_valid1();
        chk("hold_pc", opc1, cur_pc);
        chk("hold_instr", 64'(instr1), 64'(mem_fn(cur_pc)));
        chk("hold_next_pc", raddr1, cur_pc + 64'd4);
        if (tbl[i].rdy) sbq.push_back('{cur_pc, mem_fn(cur_pc)});
      end
      ready1 = tbl[i].rdy;
      redir1 = 1'b1;
      rpc1 = tbl[i].rpc;
      cyc();
      redir1 = 1'b0;
      ready1 = 1'b0;
      chk("redir_req", 64'(req1), 64'(tbl[i].exp_req));
      chk("redir_addr", raddr1, tbl[i].exp_addr);
      chk("redir_valid", 64'(valid1), 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("redir_misalign", 64'(mis1), 64'(tbl[i].exp_mis));
`endif
      in_fault = tbl[i].exp_mis;
      if (!in_fault) cur_pc = tbl[i].exp_addr;
    end
    cyc();
    chk("pre_reset_wait", 64'(req1), 64'd0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(valid1), 64'd0);
    chk("async_rst_pc", raddr1, RPC);
    chk("async_rst_out_pc", opc1, 64'd0);
    chk("async_rst_req", 64'(req1), 64'd0);
    cyc();
    sbq.push_back('{RPC, 32'h00A00093});
    rst_n = 1'b1;
    redir1 = 1'b1;
    rpc1 = 64'h7000;
    ready1 = 1'b1;
    cyc();
    redir1 = 1'b0;
    chk("idle_redir_req", 64'(req1), 64'd1);
    chk("idle_redir_addr", raddr1, RPC);
    for (k = 0; k < 10 && sbq.size() != 0; k++) cyc();
    chk("post_reset_fetch", 64'(sbq.size()), 64'd0);
    ready1 = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("lat3_req", 64'(req3), 64'd1);
    chk("lat3_addr", raddr3, RPC);
    repeat (3) cyc();
    chk("lat3_no_early", 64'(valid3), 64'd0);
    redir3 = 1'b1;
    rpc3 = 64'h2000;
    cyc();
    redir3 = 1'b0;
    chk("squash_valid", 64'(valid3), 64'd0);
    chk("squash_req", 64'(req3), 64'd1);
    chk("squash_addr", raddr3, 64'h2000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lat3_wait_valid", 64'(valid3), 64'd0);
    end
    cyc();
    e = mem_fn(64'h2000);
    chk("lat3_valid", 64'(valid3), 64'd1);
    chk("lat3_pc", opc3, 64'h2000);
    chk("lat3_instr", 64'(instr3), 64'(e));
    chk("lat3_fields", {37'd0, op3, rd3, rs13, rs23}, {37'd0, e[6:0], e[11:7], e[19:15], e[24:20]});
`ifdef FETCH_ALIGN_CHECK_EN
    chk("lat3_misalign", 64'(mis3), 64'd0);
`endif
    chk("sb_final", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
